sample_writer: RTL
==================

Name: sample_writer

Overview:
- Capture engine that writes ADC samples into the 256-byte sample memory.
- The capture is triggered and uses a circular buffer with a pre-trigger region.
- It is the producer for the UART sample-readout path: after `done`, the buffer holds 256 samples in time order, starting at `start_addr`.
- Controlled by the top-level command FSM through the same activate/done handshake used by the other memory-side blocks.

Parameters:
- DEPTH, 256, number of sample memory locations; must be a power of two.
- ADDR_W, 8, memory address width; equals log2(DEPTH).
- DATA_W, 8, ADC sample and memory data width.
- PRETRIG, 64, samples kept before the trigger; legal range 0..DEPTH-1.

Ports:
- clk_50mhz  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- activate  in  1  one-cycle start request; sampled only in ST_IDLE.
- abort  in  1  return to ST_IDLE without asserting done.
- busy  out  1  high in every state except ST_IDLE.
- done  out  1  one-cycle pulse when the capture is complete.
- sample_div  in  16  sample period in clocks, minus 1; latched on activate.
- trig_level  in  DATA_W  trigger threshold; latched on activate.
- trig_edge  in  1  0 = rising, 1 = falling; latched on activate.
- force_trig  in  1  force a trigger; has effect only in ST_WAIT_TRIG.
- adc_data  in  DATA_W  ADC sample, already synchronous to clk_50mhz.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  DATA_W  write data.
- mem_we  out  1  write strobe, one cycle per sample.
- start_addr  out  ADDR_W  address of the oldest sample; valid from done until the next activate.

Behaviour:
- Reset (asynchronous, active-low): all outputs are 0, the state is ST_IDLE, and all counters, pointers and latched settings are 0. A reset in the middle of a capture abandons it immediately; done is not asserted.
- Sample strobe: a divider counts 0..sample_div and strobes on the clock where count == sample_div. This gives one strobe every sample_div+1 clocks; sample_div = 0 strobes every clock. The divider clears on activate, so the first strobe occurs sample_div+1 clocks after activate.
- On each strobe in ST_ARM, ST_WAIT_TRIG or ST_CAPTURE, the block registers the following, so mem_we is high on the clock after the strobe:
  - mem_wdata = adc_data
  - mem_addr = wr_ptr
  - mem_we = 1
- After each write, wr_ptr increments modulo DEPTH, wrapping 255 -> 0.
- prev_sample holds the last written sample.
- States:
  - ST_IDLE: on activate, latch sample_div, trig_level and trig_edge; clear wr_ptr and the sample counter; go to ST_ARM if PRETRIG > 0, otherwise go to ST_WAIT_TRIG.
  - ST_ARM: count strobes; after the PRETRIG-th write, go to ST_WAIT_TRIG.
  - ST_WAIT_TRIG: writes continue and overwrite the oldest samples. A trigger is evaluated on each strobe:
    - Rising (trig_edge = 0): prev_sample < trig_level and adc_data >= trig_level.
    - Falling (trig_edge = 1): prev_sample > trig_level and adc_data <= trig_level.
    - Forced: force_trig is seen high on any clock in this state; it is held pending until the next strobe.
  - On the triggering strobe: trig_addr = wr_ptr; that sample is post-trigger sample 1; clear the post counter; go to ST_CAPTURE.
  - The first strobe in ST_WAIT_TRIG after ST_ARM has a valid prev_sample. With PRETRIG = 0, the edge check on the first strobe is suppressed; only force_trig can trigger there.
  - ST_CAPTURE: write until DEPTH-PRETRIG post-trigger samples have been written (trigger sample included), then go to ST_DONE.
  - ST_DONE: done = 1 for one clock; start_addr = (trig_addr - PRETRIG) mod DEPTH; go to ST_IDLE.
- activate outside ST_IDLE is ignored.
- abort in any non-idle state goes to ST_IDLE on the next clock: mem_we = 0, done is not pulsed, and start_addr is unchanged.
- abort together with a strobe: abort wins and no write occurs.
- No timeout: ST_WAIT_TRIG can be left only by a trigger, abort or reset.
- Arithmetic: counters are ADDR_W+1 bits wide so that a count of DEPTH is representable. The divider is 16 bits wide.

Decomposition:
- sample_pkg holds:
  - the state typedef: ST_IDLE, ST_ARM, ST_WAIT_TRIG, ST_CAPTURE, ST_DONE;
  - the DEPTH and ADDR_W constants;
  - the edge-select constants EDGE_RISING = 0 and EDGE_FALLING = 1.
- sample_reader imports the same package.
- One sub-module, sample_strobe_gen: clk_50mhz, reset, clear, div[15:0] -> strobe. It is reusable later for a decimating readout.

Test Plan:
- Reset during ST_CAPTURE -> busy, mem_we and done are 0 asynchronously; after release, activate starts a fresh capture with wr_ptr = 0.
- Default PRETRIG = 64, sample_div = 0, ramp 0..255 repeating, rising edge, level 100, activate:
  - 64 writes go to addresses 0..63;
  - the trigger fires when the ramp reaches 100 (stored at trig_addr);
  - 192 post-trigger writes follow;
  - done pulses once, start_addr = trig_addr - 64 mod 256, and the buffer holds the 64 samples before the trigger sample.
- sample_div = 4 -> exactly one mem_we every 5 clocks; the first mem_we occurs 6 clocks after activate.
- Constant adc_data = 50, level 100, then force_trig pulse of 1 clock between strobes, with sample_div = 9 -> trigger taken at the next strobe; done after 192 further writes including the trigger sample.
- Falling edge, level 0x80, input 0x90 -> 0x80 -> trigger; input 0x80 -> 0x80 -> no trigger.
- Wrap: hold in ST_WAIT_TRIG for 300 strobes -> mem_addr wraps 255 -> 0; start_addr is still correct modulo 256.
- abort in ST_WAIT_TRIG -> busy drops the next clock, no done, no further writes, start_addr keeps its previous value.

Source files
------------

// File: rtl/sample_pkg.sv
// Shared types and constants for the sample-memory capture and readout blocks.
package sample_pkg;

    localparam int unsigned DEPTH  = 256;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DIV_W  = 16;

    localparam logic EDGE_RISING  = 1'b0;
    localparam logic EDGE_FALLING = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT_TRIG,
        ST_CAPTURE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sample_strobe_gen.sv
// Sample-rate divider: one strobe every div+1 clocks, restarted by clear.
module sample_strobe_gen
    import sample_pkg::*;
(
    input  logic             clk_50mhz,
    input  logic             reset,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             strobe
);

    logic [DIV_W-1:0] count_q, count_d;

    always_comb begin
        strobe  = !clear && (count_q == div);
        count_d = count_q + 1'b1;
        if (clear || (count_q == div)) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sample_writer.sv
// Triggered circular-buffer capture of ADC samples into the sample memory,
// keeping PRETRIG samples ahead of the trigger.
module sample_writer #(
    parameter int unsigned DEPTH   = sample_pkg::DEPTH,
    parameter int unsigned ADDR_W  = sample_pkg::ADDR_W,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned PRETRIG = 64
) (
    input  logic                         clk_50mhz,
    input  logic                         reset,
    input  logic                         activate,
    input  logic                         abort,
    output logic                         busy,
    output logic                         done,
    input  logic [sample_pkg::DIV_W-1:0] sample_div,
    input  logic [DATA_W-1:0]            trig_level,
    input  logic                         trig_edge,
    input  logic                         force_trig,
    input  logic [DATA_W-1:0]            adc_data,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            start_addr
);

    import sample_pkg::*;

    localparam int unsigned POST = DEPTH - PRETRIG;
    localparam logic [ADDR_W:0]   PRE_CNT  = PRETRIG[ADDR_W:0];
    localparam logic [ADDR_W:0]   POST_CNT = POST[ADDR_W:0];
    localparam logic [ADDR_W-1:0] PRE_ADDR = PRETRIG[ADDR_W-1:0];

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DATA_W-1:0] level_q, level_d;
    logic              edge_q, edge_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d, cnt_inc;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              prev_valid_q, prev_valid_d;
    logic              force_pend_q, force_pend_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] start_addr_q, start_addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              strobe, strobe_clear, edge_hit, trig_hit, writing;

    assign strobe_clear = (state_q == ST_IDLE) && activate;
    assign cnt_inc      = cnt_q + 1'b1;

    sample_strobe_gen u_strobe (
        .clk_50mhz (clk_50mhz),
        .reset     (reset),
        .clear     (strobe_clear),
        .div       (div_q),
        .strobe    (strobe)
    );

    always_comb begin
        edge_hit = (edge_q == EDGE_FALLING) ? (prev_q > level_q && adc_data <= level_q)
                                            : (prev_q < level_q && adc_data >= level_q);
        // prev_valid masks the edge check until a real previous sample exists
        trig_hit = force_pend_q || force_trig || (prev_valid_q && edge_hit);
        writing  = strobe && (state_q inside {ST_ARM, ST_WAIT_TRIG, ST_CAPTURE});
    end

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        level_d      = level_q;
        edge_d       = edge_q;
        wr_ptr_d     = wr_ptr_q;
        cnt_d        = cnt_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        force_pend_d = force_pend_q;
        trig_addr_d  = trig_addr_q;
        start_addr_d = start_addr_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = 1'b0;

        if (abort && state_q != ST_IDLE) begin
            state_d      = ST_IDLE;
            force_pend_d = 1'b0;
        end else begin
            if (writing) begin
                mem_we_d     = 1'b1;
                mem_addr_d   = wr_ptr_q;
                mem_wdata_d  = adc_data;
                wr_ptr_d     = wr_ptr_q + 1'b1;
                prev_d       = adc_data;
                prev_valid_d = 1'b1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (activate) begin
                        div_d        = sample_div;
                        level_d      = trig_level;
                        edge_d       = trig_edge;
                        wr_ptr_d     = '0;
                        cnt_d        = '0;
                        prev_d       = '0;
                        prev_valid_d = 1'b0;
                        force_pend_d = 1'b0;
                        state_d      = (PRETRIG > 0) ? ST_ARM : ST_WAIT_TRIG;
                    end
                end
                ST_ARM: begin
                    if (strobe) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == PRE_CNT) state_d = ST_WAIT_TRIG;
                    end
                end
                ST_WAIT_TRIG: begin
                    force_pend_d = force_pend_q || force_trig;
                    if (strobe && trig_hit) begin
                        force_pend_d = 1'b0;
                        trig_addr_d  = wr_ptr_q;
                        cnt_d        = {{ADDR_W{1'b0}}, 1'b1};
                        if (POST_CNT == 1) begin
                            start_addr_d = wr_ptr_q - PRE_ADDR;
                            state_d      = ST_DONE;
                        end else begin
                            state_d = ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (strobe) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == POST_CNT) begin
                            start_addr_d = trig_addr_q - PRE_ADDR;
                            state_d      = ST_DONE;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            div_q        <= '0;
            level_q      <= '0;
            edge_q       <= 1'b0;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            force_pend_q <= 1'b0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            level_q      <= level_d;
            edge_q       <= edge_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            force_pend_q <= force_pend_d;
            trig_addr_q  <= trig_addr_d;
            start_addr_q <= start_addr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;
    assign start_addr = start_addr_q;

endmodule
